wb_timer_arb: RTL and testbench

Round-robin Wishbone arbiter that shares the single timer slave port between several bus masters, e.g. core data port and a debug/DMA master. It sits between the masters' `wb_bus_t` interfaces and the timer's `wb_bus_t.slave`. It grants one master at a time, holds the grant for the whole `wb_cyc` burst, and routes the slave's ack/err/read data back only to the granted master. An optional watchdog terminates transactions the slave never acknowledges.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_bus_t.sv | 18 +
 rtl/rr_picker.sv | 32 +++
 rtl/wb_timer_arb.sv | 142 ++++++++++++++
 tb/tb_wb_timer_arb.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone timer arbiter and its bus interface.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_bus_t.sv
// Classic Wishbone bus bundle; master drives the request, slave drives the response.
interface wb_bus_t;
    import wb_arb_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat_ms;
    logic [WB_DAT_W-1:0] dat_sm;
    logic                ack;
    logic                err;

    modport master (output cyc, stb, we, adr, sel, dat_ms, input dat_sm, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_ms, output dat_sm, ack, err);

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester found scanning upward from last+1.
module rr_picker #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        pick  = '0;
        idx   = '0;
        cand  = '0;
        valid = |req;
        // Walk from the farthest candidate back to last+1 so the nearest requester is written last.
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) begin
                pick       = '0;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/wb_timer_arb.sv
// Round-robin Wishbone arbiter sharing the timer slave port among N_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out beats the slave never answers.
module wb_timer_arb
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    wb_bus_t.slave               wb_masters [N_MASTERS],
    wb_bus_t.master              wb_slave,
    output logic [N_MASTERS-1:0] gnt_o
);

    localparam int IW = $clog2(N_MASTERS);

    arb_state_t           state_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [IW-1:0]        gnt_idx_q;
    logic [IW-1:0]        last_q;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] m_stb;
    logic [N_MASTERS-1:0] m_we;
    logic [WB_ADR_W-1:0]  m_adr    [N_MASTERS];
    logic [WB_SEL_W-1:0]  m_sel    [N_MASTERS];
    logic [WB_DAT_W-1:0]  m_dat_ms [N_MASTERS];

    logic [N_MASTERS-1:0] pick;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;

    logic                 g_cyc;
    logic                 g_stb;
    logic                 g_we;
    logic [WB_ADR_W-1:0]  g_adr;
    logic [WB_SEL_W-1:0]  g_sel;
    logic [WB_DAT_W-1:0]  g_dat_ms;
    logic                 to_err;

    // gnt_q is zero outside BUSY, so it alone gates every response back to the masters.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_master
        assign req[g]      = wb_masters[g].cyc;
        assign m_stb[g]    = wb_masters[g].stb;
        assign m_we[g]     = wb_masters[g].we;
        assign m_adr[g]    = wb_masters[g].adr;
        assign m_sel[g]    = wb_masters[g].sel;
        assign m_dat_ms[g] = wb_masters[g].dat_ms;

        assign wb_masters[g].ack    = gnt_q[g] & wb_slave.ack;
        assign wb_masters[g].err    = gnt_q[g] & (wb_slave.err | to_err);
        assign wb_masters[g].dat_sm = gnt_q[g] ? wb_slave.dat_sm : '0;
    end

    always_comb begin
        g_cyc    = 1'b0;
        g_stb    = 1'b0;
        g_we     = 1'b0;
        g_adr    = '0;
        g_sel    = '0;
        g_dat_ms = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_q[i]) begin
                g_cyc    = req[i];
                g_stb    = req[i] & m_stb[i];
                g_we     = m_we[i];
                g_adr    = m_adr[i];
                g_sel    = m_sel[i];
                g_dat_ms = m_dat_ms[i];
            end
        end
    end

    assign wb_slave.cyc    = g_cyc;
    assign wb_slave.stb    = g_stb & ~to_err;
    assign wb_slave.we     = g_we;
    assign wb_slave.adr    = g_adr;
    assign wb_slave.sel    = g_sel;
    assign wb_slave.dat_ms = g_dat_ms;
    assign gnt_o           = gnt_q;

    rr_picker #(
        .N (N_MASTERS)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IW'(N_MASTERS - 1);
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update together.
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q     <= pick;
                        gnt_idx_q <= pick_idx;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        last_q  <= gnt_idx_q;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;

    assign to_err = (state_q == BUSY) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

    // Counts only stalled beats; any response, idle stb or a fired timeout restarts it.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_q <= '0;
        end else if (state_q != BUSY || to_err || !g_stb || wb_slave.ack || wb_slave.err) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end
`else
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_timer_arb.sv
// Self-checking bench for wb_timer_arb: directed scenarios plus random traffic vs a behavioural model.
module tb_wb_timer_arb;
    import wb_arb_pkg::*;

    localparam int N  = 2;
    localparam int TO = TIMEOUT_CYCLES_DEFAULT;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_bus_t m_if [N] ();
    wb_bus_t s_if ();
    logic [N-1:0] gnt;

    wb_timer_arb #(.N_MASTERS(N)) dut (
        .clk        (clk),
        .rstn_i     (rstn),
        .wb_masters (m_if),
        .wb_slave   (s_if),
        .gnt_o      (gnt)
    );

    logic        m_cyc [N];
    logic        m_stb [N];
    logic        m_we  [N];
    logic [31:0] m_adr [N];
    logic [31:0] m_dat [N];
    logic [3:0]  m_sel [N];
    logic        m_ack [N];
    logic        m_err [N];
    logic [31:0] m_rd  [N];

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].cyc    = m_cyc[g];
        assign m_if[g].stb    = m_stb[g];
        assign m_if[g].we     = m_we[g];
        assign m_if[g].adr    = m_adr[g];
        assign m_if[g].sel    = m_sel[g];
        assign m_if[g].dat_ms = m_dat[g];
        assign m_ack[g]       = m_if[g].ack;
        assign m_err[g]       = m_if[g].err;
        assign m_rd[g]        = m_if[g].dat_sm;
    end

    // Timer stand-in: eight registers at 0x00..0x1C, same-cycle ack, err above that range.
    logic [31:0] tmr_reg [8];
    logic        slv_ack_en = 1'b1;
    assign s_if.ack    = s_if.cyc && s_if.stb && slv_ack_en && (s_if.adr < 32'h20);
    assign s_if.err    = s_if.cyc && s_if.stb && (s_if.adr >= 32'h20);
    assign s_if.dat_sm = tmr_reg[s_if.adr[4:2]];
    always @(posedge clk) if (s_if.ack && s_if.we) tmr_reg[s_if.adr[4:2]] <= s_if.dat_ms;

    // Reference model: who owns the bus, who was released last, and the timer contents.
    int          owner = -1;
    int          last  = N - 1;
    logic [31:0] ref_mem [8];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
    endtask

    function automatic void model_edge();
        int j;
        if (owner >= 0) begin
            if (m_cyc[owner] && m_stb[owner] && m_we[owner] && m_adr[owner] < 32'h20 && slv_ack_en)
                ref_mem[m_adr[owner][4:2]] = m_dat[owner];
            if (!m_cyc[owner]) begin
                last  = owner;
                owner = -1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (last + k) % N;
                if (m_cyc[j]) begin
                    owner = j;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        logic [N-1:0] e_gnt;
        logic         o_cyc, o_stb, mine, hit, in_rng;
        logic [31:0]  o_adr;
        e_gnt = '0;
        o_cyc = 1'b0;
        o_stb = 1'b0;
        o_adr = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            o_cyc = m_cyc[owner];
            o_stb = m_cyc[owner] && m_stb[owner];
            o_adr = m_adr[owner];
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("slv_cyc", 32'(s_if.cyc), 32'(o_cyc));
        chk("slv_stb", 32'(s_if.stb), 32'(o_stb));
        chk("slv_adr", s_if.adr, o_adr);
        for (int i = 0; i < N; i++) begin
            mine   = (i == owner);
            hit    = mine && o_stb;
            in_rng = m_adr[i] < 32'h20;
            chk($sformatf("ack%0d", i), 32'(m_ack[i]), 32'(hit && in_rng && slv_ack_en));
            chk($sformatf("err%0d", i), 32'(m_err[i]), 32'(hit && !in_rng));
            chk($sformatf("dat%0d", i), m_rd[i], mine ? ref_mem[m_adr[i][4:2]] : 32'h0);
        end
    endtask

    // One clock: inputs already set after a falling edge; check, take the edge, advance the model.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_adr[i] = adr;
        m_dat[i] = dat;
        m_sel[i] = 4'hF;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          gseq [$];
        logic [N-1:0] prev_gnt;
        int          beats [N];
        int          err_at;
        logic        stb_at_err;
        logic        err_next;
        int          n_e;

        for (int i = 0; i < 8; i++) begin
            tmr_reg[i] = '0;
            ref_mem[i] = '0;
        end
        idle_all();
        model_reset();

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_cyc", 32'(s_if.cyc), 32'h0);
        chk("rst_stb", 32'(s_if.stb), 32'h0);
        chk("rst_we", 32'(s_if.we), 32'h0);
        chk("rst_adr", s_if.adr, 32'h0);
        chk("rst_sel", 32'(s_if.sel), 32'h0);
        chk("rst_dat_ms", s_if.dat_ms, 32'h0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_ack%0d", i), 32'(m_ack[i]), 32'h0);
            chk($sformatf("rst_err%0d", i), 32'(m_err[i]), 32'h0);
            chk($sformatf("rst_dat%0d", i), m_rd[i], 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Single request from master 1: write 0xFF to 0x8, then read it back
        drive(1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0000_00FF);
        step();
        chk("t1_gnt", 32'(gnt), 32'h2);
        step();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        #1;
        chk("t1_rd", m_rd[1], 32'h0000_00FF);
        chk("t1_ack0", 32'(m_ack[0]), 32'h0);
        step();
        idle_all();
        step();
        step();

        // Contention from reset: both re-request after one beat each, grants must alternate
        rstn = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        prev_gnt = '0;
        for (int i = 0; i < N; i++) beats[i] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                if (owner != i) beats[i] = 0;
                drive(i, !(owner == i && beats[i] > 0), !(owner == i && beats[i] > 0), 1'b0,
                      32'($urandom_range(0, 7) * 4), 32'h0);
                if (owner == i && m_cyc[i]) beats[i]++;
            end
            step();
            if (gnt != '0 && gnt != prev_gnt) gseq.push_back(gnt[1] ? 1 : 0);
            prev_gnt = gnt;
        end
        chk("t2_ngrants", 32'(gseq.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_grant%0d", k), 32'(gseq[k]), 32'(k % 2));
        idle_all();
        step();
        step();

        // Burst hold: master 0 keeps cyc over 4 beats while master 1 waits
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int b = 0; b < 4; b++) begin
            drive(0, 1'b1, 1'b1, 1'b1, 32'(b * 4), $urandom);
            #1;
            chk($sformatf("t3_gnt_b%0d", b), 32'(gnt), 32'h1);
            chk($sformatf("t3_ack_b%0d", b), 32'(m_ack[0]), 32'h1);
            step();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("t3_idle", 32'(gnt), 32'h0);
        step();
        chk("t3_gnt1", 32'(gnt), 32'h2);

        // Out-of-range read by the granted master: err forwarded, grant kept
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        chk("t4_err", 32'(m_err[1]), 32'h1);
        chk("t4_ack", 32'(m_ack[1]), 32'h0);
        step();
        chk("t4_gnt", 32'(gnt), 32'h2);
        step();
        idle_all();
        step();
        step();

        // Async reset between edges during a master 1 transaction
        drive(1, 1'b1, 1'b1, 1'b1, 32'h14, $urandom);
        step();
        #1;
        chk("t5_pre_gnt", 32'(gnt), 32'h2);
        #1;
        rstn = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_cyc", 32'(s_if.cyc), 32'h0);
        chk("t5_stb", 32'(s_if.stb), 32'h0);
        chk("t5_ack1", 32'(m_ack[1]), 32'h0);
        model_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("t5_gnt0", 32'(gnt), 32'h1);
        idle_all();
        step();
        step();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                logic nc;
                nc = m_cyc[i] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 35);
                drive(i, nc, nc && ($urandom_range(0, 3) != 0), 1'($urandom),
                      32'($urandom_range(0, 9) * 4), $urandom);
            end
            step();
        end
        idle_all();
        step();
        step();

        // Slave never acknowledges
        slv_ack_en = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        step();
`ifdef WB_ARB_TIMEOUT_EN
        err_at     = -1;
        stb_at_err = 1'b1;
        err_next   = 1'b1;
        for (int t = 0; t < TO + 8; t++) begin
            #1;
            if (m_err[0] && err_at < 0) begin
                err_at     = t;
                stb_at_err = s_if.stb;
            end
            if (t == TO + 1) err_next = m_err[0];
            @(negedge clk);
        end
        chk("to_cycle", 32'(err_at), 32'(TO));
        chk("to_stb_low", 32'(stb_at_err), 32'h0);
        chk("to_single", 32'(err_next), 32'h0);
`else
        n_e = 0;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (m_err[0]) n_e++;
            @(negedge clk);
        end
        chk("no_to_err", 32'(n_e), 32'h0);
`endif
        #1;
        chk("to_gnt_held", 32'(gnt), 32'h1);
        @(negedge clk);
        slv_ack_en = 1'b1;
        idle_all();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
